hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline: IF, ID, then DEPTH stages after ID (default EX, MA, WB).
- Keeps a shadow scoreboard of in-flight destination writes, one entry per post-ID stage.
- Drives stall and flush controls and resolves the ID-stage operands Vj and Vk by forwarding, replacing the fixed 5-stage hard-wiring with a generic DEPTH-stage scheme.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width (2**AW architectural registers; address 0 is hard-zero).
- DEPTH, 3, number of post-ID stages tracked (index 0 = EX, DEPTH-1 = WB).
- LOAD_READY, 2, lowest stage index whose result is valid for a load.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ra1, id_ra2  in  AW  ID source addresses.
- id_use1, id_use2  in  1  source actually read.
- id_we3  in  1  ID instruction writes a register.
- id_wa3  in  AW  ID destination.
- id_is_load  in  1  ID instruction is a load.
- rd1, rd2  in  XLEN  register-file read data.
- stage_res  in  DEPTH*XLEN  result of each stage, stage k at bits [k*XLEN +: XLEN].
- is_branched  in  1  EX redirect this cycle.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- Vj, Vk  out  XLEN  resolved operands.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Scoreboard: DEPTH entries {v, we, wa, ld}.
  - Each cycle: sb[k] <= sb[k-1] for k >= 1.
  - sb[0] <= {1, id_we3, id_wa3, id_is_load} when id_valid & !stall & !flush; otherwise sb[0] <= 0.
- Reset (reset == 0 at an edge): all entries, stall_cnt and flush_cnt cleared.
  - stall and flush are combinational and equal 0 while the scoreboard is empty and is_branched is 0.
  - Reset mid-stall drops the pending hazard.
- Match for source s (ra_s != 0 and use_s): youngest k (lowest index) with sb[k].v & sb[k].we & sb[k].wa == ra_s.
  - Younger entries shadow older ones.
- Register 0 never matches. The operand is rd_s when there is no match, when ra_s == 0, or when use_s == 0.
- Load hazard: a match with sb[k].ld and k < LOAD_READY makes the source unresolved.
- stall = id_valid & !is_branched & (source 1 unresolved | source 2 unresolved).
- flush = is_branched. Flush overrides stall.
- Vj/Vk are combinational; they equal stage_res[k] of the matching entry, otherwise rd_s.
  - While stall is asserted the values are don't-care (a bubble is latched).
- With the default LOAD_READY = 2, load-use costs exactly 2 stall cycles after ID, then the value is forwarded from WB.
- An entry at DEPTH-1 (WB) is forwarded in the same cycle the register file is written, so no write-through requirement is placed on the register file.
- Counters:
  - stall_cnt += 1 on each cycle with stall = 1.
  - flush_cnt += 1 on each cycle with flush = 1.
  - Both saturate at 2**CNT_W - 1 and do not wrap.
- Width rules: address compare is exact on AW bits. No arithmetic is performed on data.
- Simultaneous flush and load hazard: flush = 1, stall = 0, and a bubble enters sb[0].

Optional Feature:
- Macro: HAZ_FWD_EN.
- Defined: forwarding as described above.
- Not defined: no forwarding; stage_res is ignored and Vj/Vk = rd1/rd2.
  - Any match with k < DEPTH-1 makes the source unresolved (stall).
  - A match at k = DEPTH-1 also stalls; the operand is read from the register file one cycle after WB writes it.
  - Counters behave identically in both builds.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with id_valid = 1 -> stall = 0, flush = 0, counters = 0, and Vj = rd1 after release.
- ALU back-to-back forward: issue addi x5 with EX stage_res = 0x0000_0011, then add using x5 next cycle -> stall = 0 and Vj = 0x11 from stage 0; stall_cnt unchanged.
- Load-use: lw x6 followed by add x7,x6,x6 -> stall = 1 for exactly 2 cycles, then Vj = Vk = WB stage_res (0xDEAD_BEEF); stall_cnt = 2.
- x0 hazard: write x0 in EX, then read x0 in ID with rd1 = 0 -> no stall and Vj = 0.
- Branch during load stall: is_branched = 1 while a load hazard is pending -> flush = 1, stall = 0, sb[0] bubble; flush_cnt = 1.
- HAZ_FWD_EN undefined: add x5 then use x5 -> stall = 3 cycles (DEPTH) and Vj = rd1; stall_cnt = 3.
  - With CNT_W = 2, 5 stall cycles -> stall_cnt = 3 (saturated).

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller for an in-order pipeline with DEPTH
//   post-ID stages. A shadow scoreboard follows every in-flight destination
//   write and decides, for each ID source, whether to stall, forward or use
//   the register-file value.
//   Build option: define HAZ_FWD_EN to enable operand forwarding from
//   stage_res. Without it, Vj/Vk always come from the register file and any
//   in-flight producer stalls the consumer.
module hazard_fwd_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_ra1,
    input  logic [AW-1:0]         id_ra2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  id_we3,
    input  logic [AW-1:0]         id_wa3,
    input  logic                  id_is_load,
    input  logic [XLEN-1:0]       rd1,
    input  logic [XLEN-1:0]       rd2,
    input  logic [DEPTH*XLEN-1:0] stage_res,
    input  logic                  is_branched,
    output logic                  stall,
    output logic                  flush,
    output logic [XLEN-1:0]       Vj,
    output logic [XLEN-1:0]       Vk,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] wa;
        logic          ld;
    } sb_entry_t;

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic [1:0]            hit;
    logic [1:0]            early;
    logic [1:0]            unres;
    logic [XLEN-1:0]       fwd1, fwd2;

    // Source match search: walk oldest to youngest so the youngest producer wins
    always_comb begin
        hit   = '0;
        early = '0;
        fwd1  = rd1;
        fwd2  = rd2;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_q[DEPTH-1-i].v && sb_q[DEPTH-1-i].we) begin
                if (id_use1 && (id_ra1 != '0) && (sb_q[DEPTH-1-i].wa == id_ra1)) begin
                    hit[0]   = 1'b1;
                    early[0] = sb_q[DEPTH-1-i].ld && ((DEPTH-1-i) < LOAD_READY);
                    fwd1     = stage_res[(DEPTH-1-i)*XLEN +: XLEN];
                end
                if (id_use2 && (id_ra2 != '0) && (sb_q[DEPTH-1-i].wa == id_ra2)) begin
                    hit[1]   = 1'b1;
                    early[1] = sb_q[DEPTH-1-i].ld && ((DEPTH-1-i) < LOAD_READY);
                    fwd2     = stage_res[(DEPTH-1-i)*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef HAZ_FWD_EN
    // Only a load still short of LOAD_READY blocks; everything else forwards
    assign unres = early;
    assign Vj    = fwd1;
    assign Vk    = fwd2;

    logic unused_hit;
    assign unused_hit = ^hit;
`else
    // Any in-flight producer, including WB, blocks until the register file has it
    assign unres = hit;
    assign Vj    = rd1;
    assign Vk    = rd2;

    logic unused_nofwd;
    assign unused_nofwd = ^{fwd1, fwd2, early};
`endif

    assign flush     = is_branched;
    assign stall     = id_valid & ~is_branched & (|unres);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Scoreboard shift and saturating event counters, next state
    always_comb begin
        sb_d    = '0;
        if (id_valid && !stall && !flush) begin
            sb_d[0] = '{v: 1'b1, we: id_we3, wa: id_wa3, ld: id_is_load};
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Scoreboard bench: the driver computes expected outputs from a timestamped
//   history of issued instructions and queues them; a monitor on the falling
//   edge pops and compares. A second instance with 2-bit counters checks
//   saturation. Honours HAZ_FWD_EN the same way as the design.
module tb_hazard_fwd_unit;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned AW         = 5;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned LOAD_READY = 2;
    localparam int unsigned CNT_W      = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  id_valid;
    logic [AW-1:0]         id_ra1, id_ra2, id_wa3;
    logic                  id_use1, id_use2, id_we3, id_is_load;
    logic [XLEN-1:0]       rd1, rd2;
    logic [DEPTH*XLEN-1:0] stage_res;
    logic                  is_branched;
    logic                  stall, flush, stall_s, flush_s;
    logic [XLEN-1:0]       Vj, Vk, Vj_s, Vk_s;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;
    logic [1:0]            stall_cnt_s, flush_cnt_s;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_we3(id_we3), .id_wa3(id_wa3),
        .id_is_load(id_is_load), .rd1(rd1), .rd2(rd2), .stage_res(stage_res),
        .is_branched(is_branched), .stall(stall), .flush(flush), .Vj(Vj), .Vk(Vk),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    hazard_fwd_unit #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_we3(id_we3), .id_wa3(id_wa3),
        .id_is_load(id_is_load), .rd1(rd1), .rd2(rd2), .stage_res(stage_res),
        .is_branched(is_branched), .stall(stall_s), .flush(flush_s), .Vj(Vj_s), .Vk(Vk_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s));

    typedef struct {
        logic            stall;
        logic            flush;
        logic [XLEN-1:0] vj;
        logic [XLEN-1:0] vk;
        int unsigned     scnt;
        int unsigned     fcnt;
    } exp_t;

    typedef struct {
        int unsigned   ic;
        logic          we;
        logic [AW-1:0] wa;
        logic          ld;
    } instr_t;

    exp_t   expq[$];
    instr_t hist[$];
    int unsigned cyc = 0;
    int unsigned m_scnt = 0, m_fcnt = 0;
    int unsigned errors = 0, checks = 0;

    // stimulus variables for the next cycle
    logic            t_rst, t_valid, t_use1, t_use2, t_we, t_ld, t_br;
    logic [AW-1:0]   t_ra1, t_ra2, t_wa;
    logic [XLEN-1:0] t_rd1, t_rd2;
    logic [XLEN-1:0] sr [DEPTH];
    logic            last_stall;

    function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Resolve one source from the history: stage of an entry = cycles since it left ID, minus one
    task automatic resolve(input logic [AW-1:0] ra, input logic use_s, input logic [XLEN-1:0] rdv,
                           output logic unres, output logic [XLEN-1:0] val);
        int unsigned best = DEPTH;
        logic        bld  = 1'b0;
        unres = 1'b0;
        val   = rdv;
        if (use_s && ra != 0) begin
            foreach (hist[i]) begin
                int unsigned st = cyc - hist[i].ic - 1;
                if (hist[i].we && hist[i].wa == ra && st < best) begin
                    best = st;
                    bld  = hist[i].ld;
                end
            end
            if (best < DEPTH) begin
`ifdef HAZ_FWD_EN
                unres = bld && (best < LOAD_READY);
                val   = sr[best];
`else
                unres = 1'b1;
`endif
            end
        end
    endtask

    // Drive one cycle, queue its expected outputs, then advance the model across the edge
    task automatic step();
        exp_t            e;
        logic            u1, u2;
        logic [XLEN-1:0] v1, v2;
        instr_t          n;
        @(posedge clk);
        #1;
        reset = t_rst; id_valid = t_valid; id_ra1 = t_ra1; id_ra2 = t_ra2;
        id_use1 = t_use1; id_use2 = t_use2; id_we3 = t_we; id_wa3 = t_wa;
        id_is_load = t_ld; rd1 = t_rd1; rd2 = t_rd2; is_branched = t_br;
        for (int k = 0; k < DEPTH; k++) stage_res[k*XLEN +: XLEN] = sr[k];

        resolve(t_ra1, t_use1, t_rd1, u1, v1);
        resolve(t_ra2, t_use2, t_rd2, u2, v2);
        e.flush = t_br;
        e.stall = t_valid && !t_br && (u1 || u2);
        e.vj    = v1;
        e.vk    = v2;
        e.scnt  = m_scnt;
        e.fcnt  = m_fcnt;
        expq.push_back(e);
        last_stall = e.stall;

        if (!t_rst) begin
            hist.delete();
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (e.stall) m_scnt++;
            if (e.flush) m_fcnt++;
            if (t_valid && !e.stall && !e.flush) begin
                n.ic = cyc; n.we = t_we; n.wa = t_wa; n.ld = t_ld;
                hist.push_back(n);
            end
        end
        cyc++;
        while (hist.size() > 0 && (cyc - hist[0].ic - 1) >= DEPTH) void'(hist.pop_front());
    endtask

    task automatic idle();
        t_rst = 1'b1; t_valid = 1'b0; t_use1 = 1'b0; t_use2 = 1'b0; t_we = 1'b0; t_ld = 1'b0;
        t_br = 1'b0; t_ra1 = '0; t_ra2 = '0; t_wa = '0;
        t_rd1 = $urandom; t_rd2 = $urandom;
        for (int k = 0; k < DEPTH; k++) sr[k] = $urandom;
    endtask

    task automatic issue(input logic [AW-1:0] wa, input logic ld);
        idle();
        t_valid = 1'b1; t_we = 1'b1; t_wa = wa; t_ld = ld;
        step();
    endtask

    // Consumer held in ID until it no longer stalls (bounded)
    task automatic consume(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [XLEN-1:0] fwd_val);
        for (int n = 0; n < 8; n++) begin
            idle();
            t_valid = 1'b1; t_use1 = 1'b1; t_use2 = 1'b1; t_ra1 = ra1; t_ra2 = ra2;
            t_we = 1'b1; t_wa = 5'd7;
            for (int k = 0; k < DEPTH; k++) sr[k] = fwd_val;
            step();
            if (!last_stall) return;
        end
        errors++;
        $display("FAIL consume_bound: stall still %0d after 8 cycles, expected release", last_stall);
    endtask

    // Monitor: compares each queued expectation against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("stall", XLEN'(stall), XLEN'(e.stall));
                check("flush", XLEN'(flush), XLEN'(e.flush));
                check("stall_cnt", XLEN'(stall_cnt), XLEN'(sat(e.scnt, 65535)));
                check("flush_cnt", XLEN'(flush_cnt), XLEN'(sat(e.fcnt, 65535)));
                check("stall_cnt_sat2", XLEN'(stall_cnt_s), XLEN'(sat(e.scnt, 3)));
                check("flush_cnt_sat2", XLEN'(flush_cnt_s), XLEN'(sat(e.fcnt, 3)));
                if (!e.stall) begin
                    check("Vj", Vj, e.vj);
                    check("Vk", Vk, e.vk);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b0; id_valid = 1'b0; id_ra1 = '0; id_ra2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        id_we3 = 1'b0; id_wa3 = '0; id_is_load = 1'b0; rd1 = '0; rd2 = '0; stage_res = '0;
        is_branched = 1'b0;

        // Reset held two cycles with a valid instruction in ID
        for (int i = 0; i < 2; i++) begin
            idle();
            t_rst = 1'b0; t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd3; t_we = 1'b1; t_wa = 5'd3;
            step();
        end
        idle(); step();

        // ALU producer then immediate consumer
        issue(5'd5, 1'b0);
        consume(5'd5, 5'd0, 32'h0000_0011);
        repeat (3) begin idle(); step(); end

        // Load-use
        issue(5'd6, 1'b0 | 1'b1);
        consume(5'd6, 5'd6, 32'hDEAD_BEEF);
        repeat (3) begin idle(); step(); end

        // x0 producer then x0 consumer
        issue(5'd0, 1'b0);
        idle(); t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd0; t_rd1 = '0; step();
        repeat (3) begin idle(); step(); end

        // Branch while a load hazard is pending
        issue(5'd6, 1'b1);
        idle(); t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd6; t_we = 1'b1; t_wa = 5'd8; step();
        idle(); t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd6; t_we = 1'b1; t_wa = 5'd8; t_br = 1'b1; step();
        repeat (3) begin idle(); step(); end

        // Reset in the middle of a load stall
        issue(5'd9, 1'b1);
        idle(); t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd9; step();
        idle(); t_rst = 1'b0; t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd9; step();
        idle(); t_valid = 1'b1; t_use1 = 1'b1; t_ra1 = 5'd9; step();
        idle(); step();

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            idle();
            t_rst   = ($urandom_range(0, 49) != 0);
            t_valid = ($urandom_range(0, 3) != 0);
            t_use1  = $urandom_range(0, 1);
            t_use2  = $urandom_range(0, 1);
            t_ra1   = AW'($urandom_range(0, 3));
            t_ra2   = AW'($urandom_range(0, 3));
            t_we    = ($urandom_range(0, 3) != 0);
            t_wa    = AW'($urandom_range(0, 3));
            t_ld    = ($urandom_range(0, 2) == 0);
            t_br    = ($urandom_range(0, 9) == 0);
            step();
        end

        idle(); step();
        repeat (2) @(posedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
